// File: rtl/sum_ctrl_if.sv
// -----------------------------------------------------------------------------
// sum_ctrl_if
//   Bundles the run request, the operand stream and the result/status signals
//   of the sum_ctrl accumulation controller.
//
//   Handshake: an operand transfers on every rising clk edge where in_valid
//   and in_ready are both high (a "beat"). in_ready is driven from registered
//   state only and never depends on in_valid. The source may raise or drop
//   in_valid at any time. in_data only matters on a beat.
//
//   Signals
//     start     master->slave  request a new run (honoured only when idle)
//     len       master->slave  operand count of the run, sampled with start
//     in_valid  master->slave  operand present on in_data
//     in_data   master->slave  operand
//     in_ready  slave->master  controller accepts an operand this cycle
//     busy      slave->master  run in progress
//     sum       slave->master  accumulator / final result
//     carry     slave->master  sticky carry-out of the accumulation
//     done      slave->master  one-cycle end-of-run pulse
//     fsm_state slave->master  debug view of the controller state encoding
// -----------------------------------------------------------------------------
interface sum_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic [CNT_WIDTH-1:0] len;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 busy;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic                 done;
  logic [1:0]           fsm_state;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, busy, sum, carry, done, fsm_state
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, busy, sum, carry, done, fsm_state
  );
endinterface

// File: rtl/sum_ctrl.sv
// -----------------------------------------------------------------------------
// sum_ctrl
//   Sequencing FSM for a single WIDTH-bit full adder. A run is requested with
//   start/len; the block then accepts exactly len operands from a valid/ready
//   stream, folds each into the accumulator through the adder, keeps a sticky
//   carry-out flag and finally pulses done with the result on sum/carry.
//
//   Ports
//     clk  single clock, rising edge
//     rst  asynchronous, active-high reset; aborts any run in progress
//     bus  sum_ctrl_if.slave: start, len, in_valid, in_data in;
//          in_ready, busy, sum, carry, done, fsm_state out
//
//   Every output is a flop. in_ready, busy and done are updated in the same
//   always_ff as the state register, so they are always the decode of the
//   next state and no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module sum_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  sum_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     acc;
  logic                 carry_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 done_q;

  // The shared full adder: one extra bit on top catches the carry-out.
  logic [WIDTH:0] add_res;
  assign add_res = {1'b0, acc} + {1'b0, bus.in_data};

  // in_ready_q is high exactly while in ACC, so this is the beat condition.
  logic beat;
  assign beat = in_ready_q & bus.in_valid;

  // Last operand of the run is the beat taken with one operand remaining.
  logic last_beat;
  assign last_beat = beat && (cnt == CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // sum/carry of the previous run stay visible until a new start.
          if (bus.start) begin
            acc     <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.len != '0) begin
              cnt        <= bus.len;
              state      <= ACC;
              in_ready_q <= 1'b1;
            end else begin
              // Empty run: nothing to accept, report an all-zero result.
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        ACC: begin
          if (beat) begin
            acc     <= add_res[WIDTH-1:0];
            carry_q <= carry_q | add_res[WIDTH];
            cnt     <= cnt - CNT_WIDTH'(1);
          end
          if (last_beat) begin
            state      <= DONE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end

        DONE: begin
          // start is deliberately ignored here: a new run can only be
          // accepted once the controller is back in IDLE.
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = acc;
  assign bus.carry     = carry_q;
  assign bus.done      = done_q;
  assign bus.fsm_state = state;

  // Structural invariants of the FSM, stated in terms of its outputs.
`ifndef SYNTHESIS
  a_done_one_cycle : assert property (@(posedge clk) disable iff (rst)
    done_q |=> !done_q);
  a_ready_in_acc : assert property (@(posedge clk) disable iff (rst)
    in_ready_q == (state == ACC));
  a_busy_decode : assert property (@(posedge clk) disable iff (rst)
    busy_q == (state != IDLE));
  a_done_decode : assert property (@(posedge clk) disable iff (rst)
    done_q == (state == DONE));
`endif

endmodule
